rand_gen_scheduler: RTL and testbench
=====================================

# rand_gen_scheduler

Job scheduler for the random-matrix generator. Two requesters submit generation jobs: port 0 is the UART command parser and port 1 is the key/switch panel. The block validates each job, arbitrates round-robin, and drives the generator's start/dimension/count inputs. It forwards the generator's element stream into matrix storage with computed addresses and reports completion or error to the requester.

## Interface
- MAX_DIM, 5, largest legal row/column count
- MAX_COUNT, 8, largest legal matrices per job
- MAT_STRIDE, 25, storage address stride between matrices of one job
- TIMEOUT, 1023, cycles allowed in RUN before abort
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- req0 / req1  in  1  single-cycle job request pulse
- m0, n0 / m1, n1  in  3  rows/cols, sampled with the request pulse
- cnt0 / cnt1  in  4  matrices to generate, sampled with the request pulse
- done0 / done1  out  1  one-cycle job-finished pulse
- err0 / err1  out  1  one-cycle error flag, coincident with done
- busy  out  1  high while any job is pending or running
- gen_start  out  1  one-cycle start pulse to the generator
- gen_m, gen_n  out  3  dimensions to the generator, held for the whole job
- gen_count  out  4  matrix count to the generator, held for the whole job
- gen_we  in  1  generator element valid
- gen_data  in  8  generator element
- gen_done  in  1  generator job-complete pulse
- mem_we  out  1  storage write strobe
- mem_addr  out  8  storage address
- mem_data  out  8  storage write data

## Operation
- Per-port pending flag:
  - A request pulse with pending=0 latches m/n/cnt and sets pending.
  - A request pulse with pending=1 is ignored; the latched parameters are unchanged.
- Validation is done at dispatch. A job is legal when 1 ≤ m ≤ MAX_DIM, 1 ≤ n ≤ MAX_DIM and 1 ≤ cnt ≤ MAX_COUNT.
- State machine IDLE → START → RUN → FINISH → IDLE.
- IDLE:
  - Selects a pending port. If both are pending, the port not served last wins. last_grant resets to 1, so port 0 wins the first tie.
  - An illegal job goes directly to FINISH with err set. No gen_start is issued.
  - A legal job loads gen_m/gen_n/gen_count and clears the element, matrix, write and timeout counters.
- START: gen_start=1 for exactly one cycle, then → RUN.
- RUN, on each gen_we:
  - mem_we=1, mem_data=gen_data, mem_addr = mat_idx*MAT_STRIDE + elem_idx.
  - elem_idx increments. When elem_idx reaches m*n-1 it wraps to 0 and mat_idx increments.
  - The 8-bit write counter increments.
- RUN, on gen_done: → FINISH. err = (write counter ≠ m*n*cnt). m*n*cnt is computed in 8 bits; the maximum legal value is 200.
- RUN timeout: the timeout counter increments every RUN cycle. At TIMEOUT → FINISH with err=1.
- FINISH: doneX=1 and errX as computed for the served port. Clear its pending flag, set last_grant = served port, → IDLE.
- Outside RUN, gen_we and gen_done are ignored and mem_we stays 0.
- busy = pending0 | pending1 | (state ≠ IDLE).
- A request arriving in the same cycle as FINISH for the same port sees pending=1 and is dropped.

## Timing
- Reset values:
  - State IDLE, last_grant=1, both pending flags 0.
  - All outputs 0: done0/1, err0/1, busy, gen_start, gen_m/n/count, mem_we, mem_addr, mem_data.
- Reset mid-job aborts immediately. No done pulse is produced and pending requests are lost.
- Request accepted at cycle 0 → pending/busy high at cycle 1.
- Legal job: IDLE dispatch at cycle 1, gen_start high at cycle 2.
- Illegal job: done/err pulse at cycle 2, and no gen_start.
- Storage path latency is 1 cycle: gen_we at cycle k → mem_we at cycle k+1 with the registered address and data.
- gen_done at cycle k → done pulse at cycle k+1. The state returns to IDLE at k+2, and the next dispatch can happen at k+2.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Port 0 requests m=2, n=3, cnt=1; the generator model emits 6 elements then gen_done → 6 mem_we at addr 0..5 with matching data, then done0=1, err0=0.
- Port 1 requests m=2, n=2, cnt=2 → writes at addr 0,1,2,3,25,26,27,28; done1 with err1=0; gen_count=2 held throughout.
- req0 and req1 pulse in the same cycle right after reset → port 0 is served first, then port 1. A second simultaneous pair → port 0 is served first again, because port 1 was served last.
- Port 0 requests m=0, n=3, cnt=1 → done0=err0=1 two cycles after the request; gen_start never asserts. Repeat with cnt=9 → same result.
- The model never sends gen_done, with TIMEOUT set to 40 → done0=err0=1 after 40 RUN cycles. The model sends gen_done after only 5 of 6 elements → err0=1.
- A duplicate req0 while the job is running is ignored: exactly one done0 is produced. rst_n asserted mid-RUN → all outputs 0 immediately and no done pulse.

Source files
------------

// File: rtl/rand_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rand_gen_scheduler
// Brief    : Two-port job scheduler for the random-matrix generator. Latches
//            one job per requester, validates it at dispatch, arbitrates
//            round-robin, drives the generator and forwards its element
//            stream into matrix storage with computed addresses.
// Revision : 1.0 - initial release
// ============================================================================
module rand_gen_scheduler #(
    parameter int MAX_DIM    = 5,
    parameter int MAX_COUNT  = 8,
    parameter int MAT_STRIDE = 25,
    parameter int TIMEOUT    = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [2:0] m0,
    input  logic [2:0] n0,
    input  logic [3:0] cnt0,
    input  logic       req1,
    input  logic [2:0] m1,
    input  logic [2:0] n1,
    input  logic [3:0] cnt1,
    output logic       done0,
    output logic       err0,
    output logic       done1,
    output logic       err1,
    output logic       busy,
    output logic       gen_start,
    output logic [2:0] gen_m,
    output logic [2:0] gen_n,
    output logic [3:0] gen_count,
    input  logic       gen_we,
    input  logic [7:0] gen_data,
    input  logic       gen_done,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_data
);

    // Timeout counter only needs to reach TIMEOUT-1 before the abort fires.
    localparam int              TW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0]   c_TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [2:0]      c_MAX_DIM  = 3'(MAX_DIM);
    localparam logic [3:0]      c_MAX_CNT  = 4'(MAX_COUNT);
    localparam logic [7:0]      c_STRIDE   = 8'(MAT_STRIDE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_RUN    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_fin;
    logic          w_err;

    logic          r_pend0, r_pend1;
    logic [2:0]    r_m0, r_n0, r_m1, r_n1;
    logic [3:0]    r_c0, r_c1;
    logic          r_last;
    logic          r_port;

    logic          r_done0, r_err0, r_done1, r_err1;
    logic          r_gen_start;
    logic [2:0]    r_gen_m, r_gen_n;
    logic [3:0]    r_gen_cnt;
    logic [7:0]    r_mn;
    logic [7:0]    r_total;
    logic [7:0]    r_elem;
    logic [7:0]    r_mat;
    logic [7:0]    r_wcnt;
    logic [TW-1:0] r_tmo;
    logic          r_mem_we;
    logic [7:0]    r_mem_addr, r_mem_data;

    logic          w_any;
    logic          w_sel;
    logic [2:0]    w_sm, w_sn;
    logic [3:0]    w_sc;
    logic          w_legal;
    logic          w_dispatch;
    logic          w_port;
    logic [7:0]    w_mn;
    logic [7:0]    w_wcnt_now;

    // Arbitration: a lone pending port wins; on a tie the port not served last wins.
    assign w_any      = r_pend0 | r_pend1;
    assign w_sel      = ~r_pend0 | (r_pend1 & ~r_last);
    assign w_sm       = w_sel ? r_m1 : r_m0;
    assign w_sn       = w_sel ? r_n1 : r_n0;
    assign w_sc       = w_sel ? r_c1 : r_c0;
    assign w_legal    = (w_sm != 3'd0) && (w_sm <= c_MAX_DIM) &&
                        (w_sn != 3'd0) && (w_sn <= c_MAX_DIM) &&
                        (w_sc != 4'd0) && (w_sc <= c_MAX_CNT);
    assign w_dispatch = (r_state == S_IDLE) && w_any && w_legal;
    assign w_port     = (r_state == S_IDLE) ? w_sel : r_port;
    assign w_mn       = {5'd0, w_sm} * {5'd0, w_sn};
    // A write landing in the same cycle as gen_done still counts toward the total.
    assign w_wcnt_now = r_wcnt + {7'd0, gen_we};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic plus the finish/error decision for the served port.
    always_comb begin
        w_next = r_state;
        w_fin  = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (w_legal) begin
                        w_next = S_START;
                    end else begin
                        w_next = S_FINISH;
                        w_fin  = 1'b1;
                        w_err  = 1'b1;
                    end
                end
            end
            S_START: w_next = S_RUN;
            S_RUN: begin
                if (gen_done) begin
                    w_next = S_FINISH;
                    w_fin  = 1'b1;
                    w_err  = (w_wcnt_now != r_total);
                end else if (r_tmo == c_TMO_LAST) begin
                    w_next = S_FINISH;
                    w_fin  = 1'b1;
                    w_err  = 1'b1;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Per-port pending flags and latched job parameters; cleared when that port finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend0 <= 1'b0;
            r_pend1 <= 1'b0;
            r_m0    <= 3'd0;
            r_n0    <= 3'd0;
            r_c0    <= 4'd0;
            r_m1    <= 3'd0;
            r_n1    <= 3'd0;
            r_c1    <= 4'd0;
        end else begin
            if (r_state == S_FINISH && r_port == 1'b0) begin
                r_pend0 <= 1'b0;
            end else if (req0 && !r_pend0) begin
                r_pend0 <= 1'b1;
                r_m0    <= m0;
                r_n0    <= n0;
                r_c0    <= cnt0;
            end
            if (r_state == S_FINISH && r_port == 1'b1) begin
                r_pend1 <= 1'b0;
            end else if (req1 && !r_pend1) begin
                r_pend1 <= 1'b1;
                r_m1    <= m1;
                r_n1    <= n1;
                r_c1    <= cnt1;
            end
        end
    end

    // Grant bookkeeping and registered completion pulses to the requesters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_done0 <= 1'b0;
            r_err0  <= 1'b0;
            r_done1 <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_any) r_port <= w_sel;
            if (r_state == S_FINISH)        r_last <= r_port;
            r_done0 <= w_fin & ~w_port;
            r_err0  <= w_fin & w_err & ~w_port;
            r_done1 <= w_fin & w_port;
            r_err1  <= w_fin & w_err & w_port;
        end
    end

    // Generator control, job counters and the one-cycle storage write path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen_start <= 1'b0;
            r_gen_m     <= 3'd0;
            r_gen_n     <= 3'd0;
            r_gen_cnt   <= 4'd0;
            r_mn        <= 8'd0;
            r_total     <= 8'd0;
            r_elem      <= 8'd0;
            r_mat       <= 8'd0;
            r_wcnt      <= 8'd0;
            r_tmo       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_data  <= 8'd0;
        end else begin
            r_gen_start <= w_dispatch;
            r_mem_we    <= 1'b0;
            if (w_dispatch) begin
                r_gen_m   <= w_sm;
                r_gen_n   <= w_sn;
                r_gen_cnt <= w_sc;
                r_mn      <= w_mn;
                r_total   <= w_mn * {4'd0, w_sc};
                r_elem    <= 8'd0;
                r_mat     <= 8'd0;
                r_wcnt    <= 8'd0;
                r_tmo     <= '0;
            end
            if (r_state == S_RUN) begin
                if (w_next == S_RUN) r_tmo <= r_tmo + 1'b1;
                if (gen_we) begin
                    r_mem_we   <= 1'b1;
                    r_mem_addr <= r_mat * c_STRIDE + r_elem;
                    r_mem_data <= gen_data;
                    r_wcnt     <= r_wcnt + 8'd1;
                    if (r_elem == r_mn - 8'd1) begin
                        r_elem <= 8'd0;
                        r_mat  <= r_mat + 8'd1;
                    end else begin
                        r_elem <= r_elem + 8'd1;
                    end
                end
            end
        end
    end

    assign done0     = r_done0;
    assign err0      = r_err0;
    assign done1     = r_done1;
    assign err1      = r_err1;
    assign busy      = r_pend0 | r_pend1 | (r_state != S_IDLE);
    assign gen_start = r_gen_start;
    assign gen_m     = r_gen_m;
    assign gen_n     = r_gen_n;
    assign gen_count = r_gen_cnt;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_data  = r_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_rand_gen_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rand_gen_scheduler
// Brief    : Directed self-checking bench for rand_gen_scheduler with a small
//            cycle-driven generator model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rand_gen_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [2:0] m0, n0, m1, n1;
    logic [3:0] cnt0, cnt1;
    logic       done0, err0, done1, err1, busy, gen_start;
    logic [2:0] gen_m, gen_n;
    logic [3:0] gen_count;
    logic       gen_we, gen_done;
    logic [7:0] gen_data;
    logic       mem_we;
    logic [7:0] mem_addr, mem_data;

    int n_checks = 0;
    int n_errors = 0;
    int n_done0  = 0;
    int n_done1  = 0;
    int n_gs     = 0;
    logic [7:0] q_addr[$];
    logic [7:0] q_data[$];

    rand_gen_scheduler #(
        .MAX_DIM(5), .MAX_COUNT(8), .MAT_STRIDE(25), .TIMEOUT(40)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .m0(m0), .n0(n0), .cnt0(cnt0),
        .req1(req1), .m1(m1), .n1(n1), .cnt1(cnt1),
        .done0(done0), .err0(err0), .done1(done1), .err1(err1),
        .busy(busy), .gen_start(gen_start),
        .gen_m(gen_m), .gen_n(gen_n), .gen_count(gen_count),
        .gen_we(gen_we), .gen_data(gen_data), .gen_done(gen_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: storage writes, done pulses and generator starts.
    always @(negedge clk) begin
        if (mem_we) begin
            q_addr.push_back(mem_addr);
            q_data.push_back(mem_data);
        end
        if (done0)     n_done0++;
        if (done1)     n_done1++;
        if (gen_start) n_gs++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic req(input bit p, input logic [2:0] m, input logic [2:0] n, input logic [3:0] c);
        if (!p) begin
            req0 = 1'b1; m0 = m; n0 = n; cnt0 = c;
        end else begin
            req1 = 1'b1; m1 = m; n1 = n; cnt1 = c;
        end
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic both_req();
        req0 = 1'b1; m0 = 3'd1; n0 = 3'd2; cnt0 = 4'd1;
        req1 = 1'b1; m1 = 3'd3; n1 = 3'd1; cnt1 = 4'd1;
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 50 && !gen_start; i++) tick();
        check(tag, gen_start, 1'b1);
    endtask

    // Called in the gen_start cycle; returns in the cycle after gen_done.
    task automatic drive(input int ne, input bit send_done, input logic [7:0] base);
        tick();
        for (int i = 0; i < ne; i++) begin
            gen_we   = 1'b1;
            gen_data = base + 8'(i);
            tick();
        end
        gen_we = 1'b0;
        if (send_done) begin
            gen_done = 1'b1;
            tick();
            gen_done = 1'b0;
        end
    endtask

    task automatic check_writes(input string tag, input int m, input int n, input int c, input logic [7:0] base);
        int mn;
        mn = m * n;
        check({tag, "_nwr"}, q_addr.size(), mn * c);
        for (int i = 0; i < q_addr.size() && i < mn * c; i++) begin
            check({tag, "_addr"}, q_addr[i], (i / mn) * 25 + (i % mn));
            check({tag, "_data"}, q_data[i], base + i);
        end
    endtask

    initial begin
        logic [7:0] exp2 [8];
        int snap_d0;
        int snap_gs;
        exp2 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd25, 8'd26, 8'd27, 8'd28};

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        m0 = 3'd0; n0 = 3'd0; cnt0 = 4'd0;
        m1 = 3'd0; n1 = 3'd0; cnt1 = 4'd0;
        gen_we = 1'b0; gen_done = 1'b0; gen_data = 8'd0;
        tick();
        tick();
        check("rst_ctl", {done0, done1, err0, err1, busy, gen_start, mem_we}, 0);
        check("rst_gen", {gen_m, gen_n, gen_count}, 0);
        check("rst_mem", {mem_addr, mem_data}, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 1'b0);

        // Port 0, 2x3, one matrix.
        q_addr.delete(); q_data.delete();
        req(1'b0, 3'd2, 3'd3, 4'd1);
        check("t1_busy_c1", busy, 1'b1);
        check("t1_nostart_c1", gen_start, 1'b0);
        tick();
        check("t1_start_c2", gen_start, 1'b1);
        check("t1_dims", {gen_m, gen_n, gen_count}, {3'd2, 3'd3, 4'd1});
        drive(6, 1'b1, 8'h10);
        check("t1_done0", done0, 1'b1);
        check("t1_err0", err0, 1'b0);
        check("t1_done1", done1, 1'b0);
        tick();
        check("t1_done0_pulse", done0, 1'b0);
        tick(); tick();
        check("t1_idle", busy, 1'b0);
        check_writes("t1", 2, 3, 1, 8'h10);

        // Port 1, 2x2, two matrices: second matrix at stride 25.
        q_addr.delete(); q_data.delete();
        req(1'b1, 3'd2, 3'd2, 4'd2);
        wait_start("t2_start");
        check("t2_cnt_start", gen_count, 4'd2);
        drive(8, 1'b1, 8'h40);
        check("t2_done1", done1, 1'b1);
        check("t2_err1", err1, 1'b0);
        check("t2_cnt_end", gen_count, 4'd2);
        tick(); tick(); tick();
        check("t2_nwr", q_addr.size(), 8);
        for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
            check("t2_addr", q_addr[i], exp2[i]);
            check("t2_data", q_data[i], 8'h40 + 8'(i));
        end

        // Simultaneous requests after reset: port 0 first, twice in a row.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            both_req();
            wait_start("t3_start_a");
            check("t3_first_is_p0", gen_m, 3'd1);
            drive(2, 1'b1, 8'h00);
            check("t3_done0", done0, 1'b1);
            wait_start("t3_start_b");
            check("t3_second_is_p1", gen_m, 3'd3);
            drive(3, 1'b1, 8'h00);
            check("t3_done1", done1, 1'b1);
            tick(); tick();
        end

        // Illegal jobs: done/err two cycles after the request, no gen_start.
        snap_gs = n_gs;
        req(1'b0, 3'd0, 3'd3, 4'd1);
        check("t4_done_c1", done0, 1'b0);
        tick();
        check("t4_done_c2", {done0, err0, gen_start}, 3'b110);
        tick(); tick();
        req(1'b0, 3'd2, 3'd2, 4'd9);
        tick();
        check("t4b_done_c2", {done0, err0, gen_start}, 3'b110);
        tick(); tick();
        req(1'b1, 3'd6, 3'd1, 4'd1);
        tick();
        check("t4c_done_c2", {done1, err1, gen_start}, 3'b110);
        tick(); tick();
        check("t4_no_start", n_gs, snap_gs);

        // Generator never finishes: abort after 40 RUN cycles.
        req(1'b0, 3'd2, 3'd3, 4'd1);
        wait_start("t5_start");
        tick();
        for (int i = 0; i < 39; i++) tick();
        check("t5_not_yet", done0, 1'b0);
        tick();
        check("t5_timeout", {done0, err0}, 2'b11);
        tick(); tick();

        // Short job: 5 of 6 elements.
        req(1'b0, 3'd2, 3'd3, 4'd1);
        wait_start("t5b_start");
        drive(5, 1'b1, 8'h20);
        check("t5b_short", {done0, err0}, 2'b11);
        tick(); tick();

        // Duplicate request during RUN is dropped.
        snap_d0 = n_done0;
        req(1'b0, 3'd2, 3'd1, 4'd1);
        wait_start("t6_start");
        tick();
        req0 = 1'b1; m0 = 3'd3; n0 = 3'd3; cnt0 = 4'd1;
        gen_we = 1'b1; gen_data = 8'h77;
        tick();
        req0 = 1'b0;
        gen_data = 8'h78;
        tick();
        gen_we = 1'b0;
        gen_done = 1'b1;
        tick();
        gen_done = 1'b0;
        check("t6_done", {done0, err0}, 2'b10);
        for (int i = 0; i < 6; i++) tick();
        check("t6_one_done", n_done0 - snap_d0, 1);
        check("t6_idle", busy, 1'b0);

        // Reset in the middle of RUN, with port 1 also pending.
        snap_d0 = n_done0;
        req(1'b0, 3'd5, 3'd5, 4'd1);
        wait_start("t7_start");
        tick();
        gen_we = 1'b1; gen_data = 8'h55;
        req1 = 1'b1; m1 = 3'd1; n1 = 3'd1; cnt1 = 4'd1;
        tick();
        req1 = 1'b0;
        tick();
        check("t7_pre_we", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t7_rst_ctl", {done0, done1, err0, err1, busy, gen_start, mem_we}, 0);
        check("t7_rst_gen", {gen_m, gen_n, gen_count}, 0);
        check("t7_rst_mem", {mem_addr, mem_data}, 0);
        gen_we = 1'b0;
        snap_gs = n_gs;
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t7_no_done", n_done0, snap_d0);
        check("t7_pend_lost", {busy, 31'(n_gs - snap_gs)}, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
